sr_latch_ctrl: RTL and testbench
================================

SR_LATCH_CTRL -- requirements
Module: sr_latch_ctrl

Interface
REQ-001 Parameter PULSE_W, 2, number of cycles an active-low set/reset pulse SHALL be held (legal 1..15).
REQ-002 Parameter GAP_W, 1, number of recovery cycles with both latch inputs high before Q is sampled (legal 1..15).
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 req_a / req_b  input  1  request from requester A / B; held high until the matching ack.
REQ-006 op_a / op_b  input  1  requested operation: 1 = set, 0 = reset; stable while req is high.
REQ-007 ack_a / ack_b  output  1  one-cycle completion pulse to requester A / B.
REQ-008 s_n  output  1  active-low set drive to the NAND latch, registered.
REQ-009 r_n  output  1  active-low reset drive to the NAND latch, registered.
REQ-010 q_in  input  1  latch Q output fed back.
REQ-011 q_state  output  1  last sampled latch value.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.
REQ-013 err  output  1  sticky mismatch flag.
REQ-014 err_clr  input  1  synchronous clear for err.

Function
REQ-015 FSM states SHALL be IDLE, PULSE, GAP and CHECK.
REQ-016 IDLE: when any req is high, the block SHALL grant one requester, latch its op, load the counter with PULSE_W and go to PULSE; otherwise it SHALL stay in IDLE.
REQ-017 Arbitration SHALL be round-robin with a 1-bit pointer that prefers A after reset; if both requests are high the pointer decides, and after each grant the pointer SHALL point at the other requester.
REQ-018 PULSE: s_n = 0 (op = 1) or r_n = 0 (op = 0) for exactly PULSE_W cycles, then the FSM SHALL go to GAP.
REQ-019 GAP: s_n = r_n = 1 for exactly GAP_W cycles, then the FSM SHALL go to CHECK.
REQ-020 CHECK (one cycle): the block SHALL pulse the granted requester's ack, register q_in into q_state, set err if q_in differs from op, and go to IDLE.
REQ-021 Latency: with req sampled in IDLE at cycle 0, ack SHALL be high at cycle PULSE_W+GAP_W+1, which is cycle 4 with the default parameters.
REQ-022 At least one IDLE cycle SHALL separate consecutive operations; a req still high on the cycle after its ack SHALL be treated as a new request.
REQ-023 s_n and r_n SHALL never both be 0 in any cycle, including reset entry and exit.
REQ-024 Requests arriving while busy SHALL be ignored until IDLE and never lost while held; ack_a and ack_b SHALL never be high together.
REQ-025 If err_clr and a new mismatch occur in the same cycle, set SHALL win.
REQ-026 The counter SHALL be 4 bits and never wrap; parameter values outside 1..15 SHALL be rejected at elaboration.

Reset
REQ-027 When rst_n = 0, asynchronously: state = IDLE, s_n = 1, r_n = 1, ack_a = ack_b = 0, q_state = 0, err = 0, busy = 0, pointer = A, counter = 0.
REQ-028 Reset asserted mid-operation SHALL abort the operation immediately with no ack issued; the requester SHALL re-request.

Structure
REQ-029 Package sr_ctrl_pkg SHALL hold the FSM state enum, the OP_SET / OP_RESET constants and the PULSE_W/GAP_W legal-range constants.
REQ-030 The round-robin arbiter SHALL be one sub-module, sr_rr_arb2, containing the pointer and the grant logic; the latch itself is external.

Verification
REQ-031 Reset, then req_a = 1, op_a = 1 with the latch model attached -> s_n = 0 in cycles 1-2, r_n = 1 throughout, ack_a at cycle 4, q_state = 1, err = 0.
REQ-032 req_a (op 0) and req_b (op 1) raised together at cycle 0 -> A served first, r_n = 0 in cycles 1-2, ack_a at cycle 4; B then s_n = 0 in cycles 6-7, ack_b at cycle 9, final q_state = 1.
REQ-033 q_in forced to 0 during a set operation -> err = 1 from the cycle after ack and stays 1 until err_clr; err_clr asserted in the same cycle as a second mismatch -> err stays 1.
REQ-034 rst_n driven low in the second PULSE cycle -> s_n returns to 1 asynchronously, no ack, busy = 0; after release, a held req_a completes normally at cycle 4.
REQ-035 2000 cycles of random req/op on both ports -> an assertion that s_n and r_n are never both 0 and that the acks are one-hot-or-zero always holds; with both requests held continuously, grants strictly alternate A, B, A, B.
REQ-036 PULSE_W = 1, GAP_W = 3 -> a single low cycle on the selected drive, ack at cycle 5.

Source files
------------

// File: rtl/sr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sr_ctrl_pkg
//  Description : Shared types and constants for the NAND SR-latch pulse
//                controller: FSM state encoding, operation codes and the
//                legal range of the pulse/gap length parameters.
//  Revision    : 1.0  initial release
// ============================================================================
package sr_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2,
        ST_CHECK = 2'd3
    } state_e;

    localparam logic OP_SET   = 1'b1;
    localparam logic OP_RESET = 1'b0;

    localparam int PULSE_W_MIN = 1;
    localparam int PULSE_W_MAX = 15;
    localparam int GAP_W_MIN   = 1;
    localparam int GAP_W_MAX   = 15;

    localparam int CNT_W = 4;

endpackage : sr_ctrl_pkg
`default_nettype wire

// File: rtl/sr_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : sr_rr_arb2
//  Description : Two-way round-robin arbiter. A 1-bit pointer selects the
//                preferred requester when both request together; after every
//                grant the pointer moves to the other requester.
//  Ports       : clk, rst_n    clock / async active-low reset
//                req_a, req_b  requests
//                grant_en      grants only issued while high
//                gnt_a, gnt_b  one-hot-or-zero grants (combinational)
//  Revision    : 1.0  initial release
// ============================================================================
module sr_rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    input  logic grant_en,
    output logic gnt_a,
    output logic gnt_b
);

    // 0 = A preferred, 1 = B preferred
    logic ptr_q;

    always_comb begin
        gnt_a = grant_en & req_a & (~req_b | ~ptr_q);
        gnt_b = grant_en & req_b & (~req_a |  ptr_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else if (gnt_a) begin
            ptr_q <= 1'b1;
        end else if (gnt_b) begin
            ptr_q <= 1'b0;
        end
    end

endmodule : sr_rr_arb2
`default_nettype wire

// File: rtl/sr_latch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sr_latch_ctrl
//  Description : Drives an external NAND SR latch for two requesters. Each
//                operation pulses s_n or r_n low for PULSE_W cycles, waits
//                GAP_W cycles with both drives high, then samples Q, acks
//                the requester and flags a mismatch in a sticky err bit.
//  Ports       : clk, rst_n        clock / async active-low reset
//                req_a/b, op_a/b   requests and operation (1 set, 0 reset)
//                ack_a/b           one-cycle completion pulses
//                s_n, r_n          registered active-low latch drives
//                q_in              latch Q feedback
//                q_state           last sampled Q
//                busy              FSM not idle
//                err, err_clr      sticky mismatch flag and its clear
//  Revision    : 1.0  initial release
// ============================================================================
module sr_latch_ctrl
    import sr_ctrl_pkg::*;
#(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    input  logic op_a,
    input  logic op_b,
    output logic ack_a,
    output logic ack_b,
    output logic s_n,
    output logic r_n,
    input  logic q_in,
    output logic q_state,
    output logic busy,
    output logic err,
    input  logic err_clr
);

    generate
        if (PULSE_W < PULSE_W_MIN || PULSE_W > PULSE_W_MAX) begin : g_bad_pulse_w
            $error("sr_latch_ctrl: PULSE_W out of range 1..15");
        end
        if (GAP_W < GAP_W_MIN || GAP_W > GAP_W_MAX) begin : g_bad_gap_w
            $error("sr_latch_ctrl: GAP_W out of range 1..15");
        end
    endgenerate

    localparam logic [CNT_W-1:0] PULSE_CNT = CNT_W'(PULSE_W);
    localparam logic [CNT_W-1:0] GAP_CNT   = CNT_W'(GAP_W);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_q, op_d;
    logic               sel_q, sel_d;      // 0 = A granted, 1 = B granted
    logic               s_n_q, s_n_d;
    logic               r_n_q, r_n_d;
    logic               ack_a_q, ack_a_d;
    logic               ack_b_q, ack_b_d;
    logic               q_state_q;
    logic               err_q;
    logic               gnt_a, gnt_b;
    logic               mismatch;

    sr_rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_a    (req_a),
        .req_b    (req_b),
        .grant_en (state_q == ST_IDLE),
        .gnt_a    (gnt_a),
        .gnt_b    (gnt_b)
    );

    // State register plus the registered latch drives and acks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= OP_RESET;
            sel_q     <= 1'b0;
            s_n_q     <= 1'b1;
            r_n_q     <= 1'b1;
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            q_state_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sel_q   <= sel_d;
            s_n_q   <= s_n_d;
            r_n_q   <= r_n_d;
            ack_a_q <= ack_a_d;
            ack_b_q <= ack_b_d;
            if (state_q == ST_CHECK) begin
                q_state_q <= q_in;
            end
            // A fresh mismatch beats a simultaneous clear
            err_q <= mismatch | (err_q & ~err_clr);
        end
    end

    // Next-state logic; the counter stops at its terminal value, never wraps
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sel_d   = sel_q;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_a | gnt_b) begin
                    state_d = ST_PULSE;
                    cnt_d   = PULSE_CNT;
                    op_d    = gnt_a ? op_a : op_b;
                    sel_d   = gnt_b;
                end
            end
            ST_PULSE: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_CNT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: drives are decoded from the next state so the registered
    // copies line up with the state they belong to. Only one drive can be low
    // because op_d selects exactly one of them.
    always_comb begin
        s_n_d    = ~((state_d == ST_PULSE) && (op_d == OP_SET));
        r_n_d    = ~((state_d == ST_PULSE) && (op_d == OP_RESET));
        ack_a_d  = (state_d == ST_CHECK) && !sel_d;
        ack_b_d  = (state_d == ST_CHECK) &&  sel_d;
        mismatch = (state_q == ST_CHECK) && (q_in != op_q);
        busy     = (state_q != ST_IDLE);
    end

    assign s_n     = s_n_q;
    assign r_n     = r_n_q;
    assign ack_a   = ack_a_q;
    assign ack_b   = ack_b_q;
    assign q_state = q_state_q;
    assign err     = err_q;

endmodule : sr_latch_ctrl
`default_nettype wire

// File: tb/tb_sr_latch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sr_latch_ctrl
//  Description : Directed bench for sr_latch_ctrl with a NAND latch model on
//                the feedback path. A second instance uses PULSE_W=1,
//                GAP_W=3.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sr_latch_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_a = 1'b0, req_b = 1'b0, op_a = 1'b0, op_b = 1'b0, err_clr = 1'b0;
    logic ack_a, ack_b, s_n, r_n, q_state, busy, err, q_in;
    logic force_q0 = 1'b0;
    logic lq = 1'b0;

    logic req2_a = 1'b0, req2_b = 1'b0, op2_a = 1'b0, op2_b = 1'b0, err2_clr = 1'b0;
    logic ack2_a, ack2_b, s2_n, r2_n, q2_state, busy2, err2, q2_in;
    logic lq2 = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // NAND latch models
    always @(s_n or r_n) begin
        if (!s_n) lq = 1'b1;
        else if (!r_n) lq = 1'b0;
    end
    always @(s2_n or r2_n) begin
        if (!s2_n) lq2 = 1'b1;
        else if (!r2_n) lq2 = 1'b0;
    end
    assign q_in  = force_q0 ? 1'b0 : lq;
    assign q2_in = lq2;

    sr_latch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b),
        .op_a(op_a), .op_b(op_b), .ack_a(ack_a), .ack_b(ack_b),
        .s_n(s_n), .r_n(r_n), .q_in(q_in), .q_state(q_state),
        .busy(busy), .err(err), .err_clr(err_clr)
    );

    sr_latch_ctrl #(.PULSE_W(1), .GAP_W(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_a(req2_a), .req_b(req2_b),
        .op_a(op2_a), .op_b(op2_b), .ack_a(ack2_a), .ack_b(ack2_b),
        .s_n(s2_n), .r_n(r2_n), .q_in(q2_in), .q_state(q2_state),
        .busy(busy2), .err(err2), .err_clr(err2_clr)
    );

    task automatic do_reset();
        req_a = 0; req_b = 0; op_a = 0; op_b = 0; err_clr = 0; force_q0 = 0;
        req2_a = 0; op2_a = 0;
        rst_n = 0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        req_a = 1; req_b = 1; op_a = 1;
        @(negedge clk);
        total++; if ({s_n, r_n, ack_a, ack_b, q_state, err, busy} !== 7'b1100000) begin
            bad++; $display("FAIL reset_dut outs got %b want 1100000", {s_n, r_n, ack_a, ack_b, q_state, err, busy});
        end
        total++; if ({s2_n, r2_n, ack2_a, ack2_b, q2_state, err2, busy2} !== 7'b1100000) begin
            bad++; $display("FAIL reset_dut2 outs got %b want 1100000", {s2_n, r2_n, ack2_a, ack2_b, q2_state, err2, busy2});
        end
        @(negedge clk);
        total++; if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_hold busy got %b want 0", busy);
        end
        req_a = 0; req_b = 0; op_a = 0;
        do_reset();
    endtask

    task automatic test_single_set();
        logic es;
        do_reset();
        @(posedge clk); #1; req_a = 1; op_a = 1;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            es = (k == 1 || k == 2) ? 1'b0 : 1'b1;
            total++; if (s_n !== es) begin bad++; $display("FAIL single_set s_n cyc %0d got %b want %b", k, s_n, es); end
            total++; if (r_n !== 1'b1) begin bad++; $display("FAIL single_set r_n cyc %0d got %b want 1", k, r_n); end
            total++; if (ack_a !== (k == 4)) begin bad++; $display("FAIL single_set ack_a cyc %0d got %b want %b", k, ack_a, k == 4); end
            total++; if (ack_b !== 1'b0) begin bad++; $display("FAIL single_set ack_b cyc %0d got %b want 0", k, ack_b); end
            total++; if (busy !== (k >= 1 && k <= 4)) begin bad++; $display("FAIL single_set busy cyc %0d got %b want %b", k, busy, (k >= 1 && k <= 4)); end
            if (k == 4) req_a = 0;
        end
        total++; if (q_state !== 1'b1) begin bad++; $display("FAIL single_set q_state got %b want 1", q_state); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL single_set err got %b want 0", err); end
    endtask

    task automatic test_both();
        logic es, er;
        do_reset();
        @(posedge clk); #1; req_a = 1; op_a = 0; req_b = 1; op_b = 1;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            er = (k == 1 || k == 2) ? 1'b0 : 1'b1;
            es = (k == 6 || k == 7) ? 1'b0 : 1'b1;
            total++; if (r_n !== er) begin bad++; $display("FAIL both r_n cyc %0d got %b want %b", k, r_n, er); end
            total++; if (s_n !== es) begin bad++; $display("FAIL both s_n cyc %0d got %b want %b", k, s_n, es); end
            total++; if (ack_a !== (k == 4)) begin bad++; $display("FAIL both ack_a cyc %0d got %b want %b", k, ack_a, k == 4); end
            total++; if (ack_b !== (k == 9)) begin bad++; $display("FAIL both ack_b cyc %0d got %b want %b", k, ack_b, k == 9); end
            if (k == 5) begin
                total++; if (q_state !== 1'b0) begin bad++; $display("FAIL both q_state_after_a got %b want 0", q_state); end
            end
            if (k == 4) req_a = 0;
            if (k == 9) req_b = 0;
        end
        total++; if (q_state !== 1'b1) begin bad++; $display("FAIL both q_state_final got %b want 1", q_state); end
    endtask

    task automatic test_err();
        do_reset();
        force_q0 = 1;
        @(posedge clk); #1; req_a = 1; op_a = 1;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            total++; if (err !== (k >= 5)) begin bad++; $display("FAIL err_set cyc %0d got %b want %b", k, err, k >= 5); end
            if (k == 4) req_a = 0;
        end
        total++; if (q_state !== 1'b0) begin bad++; $display("FAIL err q_state got %b want 0", q_state); end
        err_clr = 1;
        @(negedge clk);
        err_clr = 0;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear got %b want 0", err); end
        @(posedge clk); #1; req_a = 1;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            total++; if (err !== (k == 5)) begin bad++; $display("FAIL err_clr_race cyc %0d got %b want %b", k, err, k == 5); end
            if (k == 4) begin err_clr = 1; req_a = 0; end
        end
        err_clr = 0;
        force_q0 = 0;
    endtask

    task automatic test_reset_abort();
        logic es;
        do_reset();
        @(posedge clk); #1; req_a = 1; op_a = 1;
        @(negedge clk); @(negedge clk); @(negedge clk);
        total++; if (s_n !== 1'b0) begin bad++; $display("FAIL abort pre s_n got %b want 0", s_n); end
        rst_n = 0;
        #1;
        total++; if (s_n !== 1'b1) begin bad++; $display("FAIL abort s_n got %b want 1", s_n); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort busy got %b want 0", busy); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (ack_a !== 1'b0) begin bad++; $display("FAIL abort ack_a got %b want 0", ack_a); end
        end
        rst_n = 1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            es = (k == 1 || k == 2) ? 1'b0 : 1'b1;
            total++; if (s_n !== es) begin bad++; $display("FAIL abort_rerun s_n cyc %0d got %b want %b", k, s_n, es); end
            total++; if (ack_a !== (k == 4)) begin bad++; $display("FAIL abort_rerun ack_a cyc %0d got %b want %b", k, ack_a, k == 4); end
            if (k == 4) req_a = 0;
        end
    endtask

    task automatic test_alternate();
        int n = 0;
        int cyc = 0;
        do_reset();
        @(posedge clk); #1; req_a = 1; req_b = 1; op_a = 1; op_b = 0;
        while (n < 6 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (ack_a || ack_b) begin
                total++; if (ack_a !== (n % 2 == 0) || ack_b !== (n % 2 == 1)) begin
                    bad++; $display("FAIL alternate grant %0d got a=%b b=%b want a=%b", n, ack_a, ack_b, n % 2 == 0);
                end
                n++;
            end
        end
        total++; if (n != 6) begin bad++; $display("FAIL alternate timeout acks got %0d want 6", n); end
        req_a = 0; req_b = 0;
    endtask

    task automatic test_random();
        int wa = 0;
        int wb = 0;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            total++; if (!s_n && !r_n) begin bad++; $display("FAIL random both_low cyc %0d got s_n=%b r_n=%b want not both 0", c, s_n, r_n); end
            total++; if (ack_a && ack_b) begin bad++; $display("FAIL random ack_onehot cyc %0d got a=%b b=%b want not both 1", c, ack_a, ack_b); end
            if (ack_a) begin req_a = 0; wa = 0; end
            else if (req_a) begin
                wa++;
                if (wa == 21) begin total++; bad++; $display("FAIL random lost_a got wait %0d want <=20", wa); end
            end else if ($urandom_range(0, 2) == 0) begin req_a = 1; op_a = 1'($urandom_range(0, 1)); end
            if (ack_b) begin req_b = 0; wb = 0; end
            else if (req_b) begin
                wb++;
                if (wb == 21) begin total++; bad++; $display("FAIL random lost_b got wait %0d want <=20", wb); end
            end else if ($urandom_range(0, 2) == 0) begin req_b = 1; op_b = 1'($urandom_range(0, 1)); end
            err_clr = 1'($urandom_range(0, 1));
        end
        req_a = 0; req_b = 0; err_clr = 0;
    endtask

    task automatic test_short();
        logic es;
        do_reset();
        @(posedge clk); #1; req2_a = 1; op2_a = 1;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            es = (k == 1) ? 1'b0 : 1'b1;
            total++; if (s2_n !== es) begin bad++; $display("FAIL short s_n cyc %0d got %b want %b", k, s2_n, es); end
            total++; if (r2_n !== 1'b1) begin bad++; $display("FAIL short r_n cyc %0d got %b want 1", k, r2_n); end
            total++; if (ack2_a !== (k == 5)) begin bad++; $display("FAIL short ack cyc %0d got %b want %b", k, ack2_a, k == 5); end
            if (k == 5) req2_a = 0;
        end
        total++; if (q2_state !== 1'b1) begin bad++; $display("FAIL short q_state got %b want 1", q2_state); end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_set();
        test_both();
        test_err();
        test_reset_abort();
        test_alternate();
        test_random();
        test_short();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sr_latch_ctrl
`default_nettype wire
